// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        F_MUL    = 2'b00,
        F_MULH   = 2'b01,
        F_MULHSU = 2'b10,
        F_MULHU  = 2'b11
    } funct_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P0   = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_P3   = 3'd4,
        S_SIGN = 3'd5,
        S_DONE = 3'd6
    } state_e;

    localparam int unsigned SH_P0 = 0;
    localparam int unsigned SH_P1 = 16;
    localparam int unsigned SH_P2 = 16;
    localparam int unsigned SH_P3 = 32;

    function automatic logic signed_a(input funct_e f);
        return (f == F_MULH) || (f == F_MULHSU);
    endfunction

    function automatic logic signed_b(input funct_e f);
        return (f == F_MULH);
    endfunction

endpackage

// File: rtl/sb_mac16.sv
// 16x16 multiplier slice with optional input/product registers and output selects.
module sb_mac16 #(
    parameter bit         A_REG            = 1'b0,
    parameter bit         B_REG            = 1'b0,
    parameter bit         MULT_REG         = 1'b0,
    parameter bit         A_SIGNED         = 1'b0,
    parameter bit         B_SIGNED         = 1'b0,
    parameter logic [1:0] TOPOUTPUT_SELECT = 2'b11,
    parameter logic [1:0] BOTOUTPUT_SELECT = 2'b11
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        CE,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [31:0] O
);

    logic [15:0]        a_q, b_q, a_s, b_s;
    logic signed [16:0] a_e, b_e;
    logic [31:0]        p16;
    logic [15:0]        p8_hi, p8_lo;
    logic [63:0]        prod_q, prod_c, prod;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
        end else if (CE) begin
            a_q    <= A;
            b_q    <= B;
            prod_q <= prod_c;
        end
    end

    always_comb begin
        a_s   = A_REG ? a_q : A;
        b_s   = B_REG ? b_q : B;
        a_e   = {A_SIGNED & a_s[15], a_s};
        b_e   = {B_SIGNED & b_s[15], b_s};
        // A 16x16 product of either signedness fits in the low 32 bits.
        p16   = 32'(a_e) * 32'(b_e);
        p8_hi = {8'b0, a_s[15:8]} * {8'b0, b_s[15:8]};
        p8_lo = {8'b0, a_s[7:0]} * {8'b0, b_s[7:0]};
        prod_c = {p16, p8_hi, p8_lo};
        prod   = MULT_REG ? prod_q : prod_c;
    end

    always_comb begin
        case (TOPOUTPUT_SELECT)
            2'b11:   O[31:16] = prod[63:48];
            2'b10:   O[31:16] = prod[31:16];
            default: O[31:16] = '0;
        endcase
        case (BOTOUTPUT_SELECT)
            2'b11:   O[15:0] = prod[47:32];
            2'b10:   O[15:0] = prod[15:0];
            default: O[15:0] = '0;
        endcase
    end

endmodule

// File: rtl/mul32_seq.sv
// RV32M multiplier: four 16x16 partial products on one multiplier, then sign fix-up.
module mul32_seq
    import mul_pkg::*;
#(
    parameter bit NEG_OUT = 1'b0
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        START,
    input  logic [1:0]  FUNCT,
    input  logic [31:0] RS1,
    input  logic [31:0] RS2,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT
);

    logic        clk_g;
    state_e      state_q, state_d;
    funct_e      funct_q, funct_d, funct_in;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        neg_q, neg_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic        sa, sb;
    logic [15:0] mul_a, mul_b;
    logic [31:0] pp;
    logic [63:0] pp_sh, acc_fix;

    assign clk_g = CLK ^ NEG_OUT;

    sb_mac16 #(
        .A_REG            (1'b0),
        .B_REG            (1'b0),
        .MULT_REG         (1'b0),
        .A_SIGNED         (1'b0),
        .B_SIGNED         (1'b0),
        .TOPOUTPUT_SELECT (2'b11),
        .BOTOUTPUT_SELECT (2'b11)
    ) u_mac (
        .CLK  (clk_g),
        .RSTN (RSTN),
        .CE   (1'b1),
        .A    (mul_a),
        .B    (mul_b),
        .O    (pp)
    );

    always_comb begin
        funct_in = funct_e'(FUNCT);
        sa       = signed_a(funct_in);
        sb       = signed_b(funct_in);
        mul_a    = (state_q == S_P0 || state_q == S_P1) ? a_q[15:0] : a_q[31:16];
        mul_b    = (state_q == S_P0 || state_q == S_P2) ? b_q[15:0] : b_q[31:16];
        case (state_q)
            S_P1:    pp_sh = {32'b0, pp} << SH_P1;
            S_P2:    pp_sh = {32'b0, pp} << SH_P2;
            S_P3:    pp_sh = {32'b0, pp} << SH_P3;
            default: pp_sh = {32'b0, pp} << SH_P0;
        endcase
        acc_fix = neg_q ? (~acc_q + 64'd1) : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        funct_d  = funct_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_P0;
                    funct_d = funct_in;
                    a_d     = (sa & RS1[31]) ? (~RS1 + 32'd1) : RS1;
                    b_d     = (sb & RS2[31]) ? (~RS2 + 32'd1) : RS2;
                    neg_d   = (sa & RS1[31]) ^ (sb & RS2[31]);
                    acc_d   = '0;
                end
            end
            S_P0: begin acc_d = acc_q + pp_sh; state_d = S_P1; end
            S_P1: begin acc_d = acc_q + pp_sh; state_d = S_P2; end
            S_P2: begin acc_d = acc_q + pp_sh; state_d = S_P3; end
            S_P3: begin acc_d = acc_q + pp_sh; state_d = S_SIGN; end
            S_SIGN: begin
                // Result is taken from the fixed-up sum so it is valid in the DONE cycle.
                acc_d    = acc_fix;
                result_d = (funct_q == F_MUL) ? acc_fix[31:0] : acc_fix[63:32];
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_g or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= S_IDLE;
            funct_q  <= F_MUL;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            funct_q  <= funct_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign BUSY   = (state_q == S_P1) || (state_q == S_P2) ||
                    (state_q == S_P3) || (state_q == S_SIGN);
    assign DONE   = (state_q == S_DONE);
    assign RESULT = result_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Randomized and directed self-checking bench for mul32_seq against a 64-bit arithmetic model.
module tb_mul32_seq;

    logic        CLK;
    logic        RSTN;
    logic        START;
    logic [1:0]  FUNCT;
    logic [31:0] RS1, RS2;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int n_checks = 0;
    int n_fail   = 0;

    mul32_seq #(.NEG_OUT(1'b0)) dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .START  (START),
        .FUNCT  (FUNCT),
        .RS1    (RS1),
        .RS2    (RS2),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f == 2'b01 || f == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (f == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Starts an operation (caller sits 1 time unit after a rising edge, DUT idle),
    // scrambles inputs after acceptance, optionally re-pulses START, waits for DONE.
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int pulse_at, output logic [31:0] res,
                          output int lat, output int busy_cnt);
        FUNCT = f; RS1 = a; RS2 = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        FUNCT = 2'($urandom); RS1 = $urandom; RS2 = $urandom;
        lat = -1; busy_cnt = 0; res = '0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge CLK); #1;
            START = (i == pulse_at);
            if (START) RS1 = ~RS1;
            if (BUSY) busy_cnt++;
            if (DONE) begin
                lat = i;
                res = RESULT;
                break;
            end
        end
        START = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b result=%h required 0 0 00000000", BUSY, DONE, RESULT);
        end
    endtask

    typedef struct packed {
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[7];
        logic [31:0] res;
        int lat, bc;
        vecs = '{
            '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A},
            '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
            '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000},
            '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF},
            '{2'b00, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000}
        };
        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, -1, res, lat, bc);
            n_checks++;
            if (lat !== 5) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d required 5", i, lat);
            end
            n_checks++;
            if (bc !== 4) begin
                n_fail++;
                $display("FAIL directed_busy[%0d]: busy cycles %0d required 4", i, bc);
            end
            n_checks++;
            if (res !== vecs[i].e) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got %h required %h", i, res, vecs[i].e);
            end
            idle_cycle();
            n_checks++;
            if (DONE !== 1'b0 || RESULT !== vecs[i].e) begin
                n_fail++;
                $display("FAIL directed_hold[%0d]: done=%b result=%h required 0 %h", i, DONE, RESULT, vecs[i].e);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp;
        logic [1:0]  f;
        int lat, bc;
        for (int i = 0; i < 40; i++) begin
            f   = 2'($urandom);
            a   = pick_operand();
            b   = pick_operand();
            exp = ref_mul(f, a, b);
            run_op(f, a, b, -1, res, lat, bc);
            n_checks++;
            if (lat !== 5 || bc !== 4 || res !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] f=%0d a=%h b=%h: result=%h lat=%0d busy=%0d required %h 5 4",
                         i, f, a, b, res, lat, bc, exp);
            end
            idle_cycle();
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] a, b, res, exp;
        int lat, bc;
        a = $urandom | 32'h0001_0001;
        b = $urandom | 32'h0001_0001;
        exp = ref_mul(2'b11, a, b);
        run_op(2'b11, a, b, 2, res, lat, bc);
        n_checks++;
        if (lat !== 5 || res !== exp) begin
            n_fail++;
            $display("FAIL ignore_start: result=%h lat=%0d required %h 5", res, lat, exp);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, res, exp1, exp2;
        int lat, bc;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom;
        exp1 = ref_mul(2'b00, a1, b1);
        exp2 = ref_mul(2'b01, a2, b2);
        run_op(2'b00, a1, b1, -1, res, lat, bc);
        n_checks++;
        if (res !== exp1) begin
            n_fail++;
            $display("FAIL b2b_first: got %h required %h", res, exp1);
        end
        FUNCT = 2'b01; RS1 = a2; RS2 = b2; START = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || RESULT !== exp1) begin
            n_fail++;
            $display("FAIL b2b_ignored: done=%b busy=%b result=%h required 0 0 %h", DONE, BUSY, RESULT, exp1);
        end
        @(posedge CLK); #1;
        START = 1'b0;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge CLK); #1;
            if (DONE) begin
                lat = i;
                break;
            end
        end
        n_checks++;
        if (lat !== 5 || RESULT !== exp2) begin
            n_fail++;
            $display("FAIL b2b_second: result=%h lat=%0d required %h 5", RESULT, lat, exp2);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        int lat, bc, seen_done;
        run_op(2'b00, 32'd7, 32'd6, -1, res, lat, bc);
        idle_cycle();
        FUNCT = 2'b11; RS1 = $urandom; RS2 = $urandom; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        RSTN = 1'b0;
        #1;
        n_checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'h0) begin
            n_fail++;
            $display("FAIL midop_reset: busy=%b done=%b result=%h required 0 0 00000000", BUSY, DONE, RESULT);
        end
        @(posedge CLK); #2;
        RSTN = 1'b1;
        @(posedge CLK); #1;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (DONE || BUSY) seen_done++;
            @(posedge CLK); #1;
        end
        n_checks++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL midop_abort: active cycles %0d required 0", seen_done);
        end
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, res, lat, bc);
        n_checks++;
        if (lat !== 5 || res !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL midop_restart: result=%h lat=%0d required fffffffe 5", res, lat);
        end
        idle_cycle();
    endtask

    initial begin
        RSTN = 1'b0; START = 1'b0; FUNCT = 2'b00; RS1 = '0; RS2 = '0;
        #1;
        test_reset();
        @(posedge CLK); #2;
        RSTN = 1'b1;
        @(posedge CLK); #1;
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul32_seq.md
MUL32_SEQ -- requirements
Module: mul32_seq

Interface
REQ-001 Parameter: NEG_OUT, default 0, when 1 the result register also loads on CLK falling edge (all sequential logic uses CLK ^ NEG_OUT).
REQ-002 CLK  input  1  processor clock.
REQ-003 RSTN  input  1  reset, asynchronous, active-low.
REQ-004 START  input  1  request a multiply; sampled only in IDLE.
REQ-005 FUNCT  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (RV32M funct3[1:0]).
REQ-006 RS1  input  32  multiplicand; sampled with START.
REQ-007 RS2  input  32  multiplier; sampled with START.
REQ-008 BUSY  output  1  high from the cycle after START is accepted until DONE.
REQ-009 DONE  output  1  one-cycle pulse; RESULT is valid from this cycle on.
REQ-010 RESULT  output  32  product low word for MUL, high word otherwise.

Function
REQ-011 The block shall compute the 64-bit product through one unsigned 16x16 multiplier, one partial product per cycle.
REQ-012 States shall be IDLE, P0, P1, P2, P3, SIGN, DONE.
REQ-013 Transitions: IDLE->P0 on START; P0->P1->P2->P3->SIGN->DONE unconditionally; DONE->IDLE.
REQ-014 On START in IDLE: latch |RS1| and |RS2| and neg = sa&RS1[31] ^ sb&RS2[31]; clear the 64-bit accumulator.
REQ-015 Signedness: sa = (FUNCT==01 or 10); sb = (FUNCT==01).
REQ-016 Magnitude of 0x80000000 shall be 0x80000000 as a 32-bit unsigned value; no overflow.
REQ-017 Partial products: P0 Al*Bl added at shift 0, P1 Al*Bh at 16, P2 Ah*Bl at 16, P3 Ah*Bh at 32; adds are 64-bit modulo 2^64.
REQ-018 SIGN: accumulator = neg ? two's-complement negation : unchanged.
REQ-019 DONE state: RESULT loads acc[31:0] (MUL) or acc[63:32] (others); DONE=1 for exactly this cycle.
REQ-020 Latency: START sampled at edge k -> DONE high after edge k+5; BUSY high after edges k+1 to k+4 and low with DONE.
REQ-021 START while not IDLE shall be ignored; operands are not re-sampled.
REQ-022 A START that coincides with the DONE cycle is ignored; the next START is accepted in IDLE, giving back-to-back throughput of one multiply per 6 cycles.
REQ-023 RESULT shall hold its value until the next DONE; FUNCT or RS changes mid-operation have no effect.

Reset
REQ-024 RSTN low shall immediately force state IDLE, BUSY=0, DONE=0, RESULT=0, and clear the accumulator and operand registers.
REQ-025 Reset mid-operation shall abort the multiply with no DONE; the first START after RSTN rises shall be accepted normally.

Structure
REQ-026 Package mul_pkg holds the FUNCT codes, state encoding and partial-product shift constants.
REQ-027 One sub-module: sb_mac16, configured as 16x16 unsigned, combinational (all REG parameters 0, outputs select iH) and acting as the multiplier stage.
REQ-028 The operand-half muxes (Al, Ah, Bl, Bh) are driven by state; the accumulator and sign logic are local.

Verification
REQ-029 MUL 0x00000007 x 0x00000006 -> DONE at k+5, RESULT=0x0000002A, BUSY high for 4 cycles.
REQ-030 MULH 0x80000000 x 0x80000000 -> RESULT=0x40000000; MUL on the same operands -> 0x00000000.
REQ-031 MULHSU 0xFFFFFFFF (-1) x 0xFFFFFFFF (unsigned) -> RESULT=0xFFFFFFFF; MULHU on the same operands -> 0xFFFFFFFE.
REQ-032 MULH 0xFFFFFFFF x 0x00000001 -> RESULT=0xFFFFFFFF; MUL 0x12345678 x 0 -> RESULT=0.
REQ-033 START pulsed again in P2, with changed RS1 -> ignored, original RESULT; back-to-back START on the DONE cycle -> ignored; START one cycle later -> accepted.
REQ-034 RSTN low during P1 -> BUSY=0 and RESULT=0 at once, no DONE; a fresh MULHU 0xFFFFFFFF x 0xFFFFFFFF then gives 0xFFFFFFFE.
